pong_btn_cond: RTL and testbench



---
 rtl/pong_pkg.sv | 27 ++
 rtl/pong_debounce_ch.sv | 142 ++++++++++++++
 rtl/pong_btn_cond.sv | 50 +++++
 tb/tb_pong_btn_cond.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong definitions: debounce FSM state encoding, default timing constants
// and the push-button bit indices.
package pong_pkg;

  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressPend   = 2'd1,
    StPressed     = 2'd2,
    StReleasePend = 2'd3
  } btn_state_e;

  // 10 ms debounce and repeat timing at 100 MHz
  localparam int unsigned DebCyclesDef    = 1_000_000;
  localparam int unsigned RepeatDelayDef  = 50_000_000;
  localparam int unsigned RepeatPeriodDef = 10_000_000;

  localparam int unsigned BtnD = 0;
  localparam int unsigned BtnU = 1;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pong_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM with saturating counter,
// press/release pulses. Auto-repeat on held press when PONG_BTN_REPEAT_EN is defined.
module pong_debounce_ch
  import pong_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DebCyclesDef,
  parameter int unsigned REPEAT_DELAY  = RepeatDelayDef,
  parameter int unsigned REPEAT_PERIOD = RepeatPeriodDef
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic press_next_o
);

  localparam int unsigned CntW = $clog2(max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
  typedef logic [CntW-1:0] cnt_t;

  // Counter is cleared on entry to a pending state, so acceptance lands on the
  // DEB_CYCLES-th consecutive stable sample.
  localparam cnt_t DebLast = cnt_t'(DEB_CYCLES - 2);
  localparam cnt_t CntMax  = '1;

  logic [1:0] sync_q;
  logic       s;
  btn_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d, cnt_inc;
  logic       level_q, level_d;
  logic       press_q, press_d;
  logic       release_q, release_d;

`ifdef PONG_BTN_REPEAT_EN
  localparam cnt_t RepDelayLast  = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t RepPeriodLast = cnt_t'(REPEAT_PERIOD - 1);
  logic rep_q, rep_d;
`endif

  assign s       = sync_q[1];
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + cnt_t'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef PONG_BTN_REPEAT_EN
    rep_d     = rep_q;
`endif
    unique case (state_q)
      StReleased: begin
        if (s) begin
          state_d = StPressPend;
          cnt_d   = '0;
        end
      end
      StPressPend: begin
        if (!s) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StPressed;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
`ifdef PONG_BTN_REPEAT_EN
          rep_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StPressed: begin
        if (!s) begin
          state_d = StReleasePend;
          cnt_d   = '0;
`ifdef PONG_BTN_REPEAT_EN
        end else if ((!rep_q && cnt_q == RepDelayLast) || (rep_q && cnt_q == RepPeriodLast)) begin
          press_d = 1'b1;
          rep_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
`endif
        end
      end
      StReleasePend: begin
        if (s) begin
          state_d = StPressed;
          cnt_d   = '0;
`ifdef PONG_BTN_REPEAT_EN
          rep_d   = 1'b0;
`endif
        end else if (cnt_q == DebLast) begin
          state_d   = StReleased;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      state_q   <= StReleased;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef PONG_BTN_REPEAT_EN
      rep_q     <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], btn_raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef PONG_BTN_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign press_next_o = press_d;

endmodule

// File: rtl/pong_btn_cond.sv
// Button conditioner: N_BTN independent debounce channels plus a registered any_press.
// Optional auto-repeat is enabled with `define PONG_BTN_REPEAT_EN.
module pong_btn_cond
  import pong_pkg::*;
#(
  parameter int unsigned N_BTN         = 2,
  parameter int unsigned DEB_CYCLES    = DebCyclesDef,
  parameter int unsigned REPEAT_DELAY  = RepeatDelayDef,
  parameter int unsigned REPEAT_PERIOD = RepeatPeriodDef
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  logic [N_BTN-1:0] press_next;
  logic             any_press_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    pong_debounce_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_raw_i   (btn_raw[i]),
      .level_o     (btn_level[i]),
      .press_o     (btn_press[i]),
      .release_o   (btn_release[i]),
      .press_next_o(press_next[i])
    );
  end

  // Registered from next-state pulses so it aligns with btn_press
  always_ff @(posedge clk) begin
    if (!reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_next;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_pong_btn_cond.sv
// Directed bench for pong_btn_cond with DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_pong_btn_cond;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_level, btn_press, btn_release;
  logic       any_press;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  pong_btn_cond #(
    .N_BTN        (2),
    .DEB_CYCLES   (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed {any_press, release, press, level}
  function automatic logic [6:0] ev(input logic [1:0] lvl, input logic [1:0] prs,
                                    input logic [1:0] rel);
    return {|prs, rel, prs, lvl};
  endfunction

  task automatic chk(input string tag, input int e, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {any_press, btn_release, btn_press, btn_level};
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] l, p, r;

    // 1: reset with both buttons held, then acceptance 5 edges after first sample
    reset   = 1'b0;
    btn_raw = 2'b11;
    for (int e = 0; e < 3; e++) begin
      step();
      chk("reset_hold", e, 7'd0);
    end
    reset = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      l = (e >= 5) ? 2'b11 : 2'b00;
      p = (e == 5) ? 2'b11 : 2'b00;
      chk("reset_accept", e, ev(l, p, 2'b00));
    end
    btn_raw = 2'b00;
    for (int e = 0; e < 7; e++) begin
      step();
      l = (e < 5) ? 2'b11 : 2'b00;
      r = (e == 5) ? 2'b11 : 2'b00;
      chk("both_release", e, ev(l, 2'b00, r));
    end

    // 2: clean press on btnD, release sampled at edge 20
    btn_raw = 2'b01;
    for (int e = 0; e < 27; e++) begin
      step();
      l = (e >= 5 && e < 25) ? 2'b01 : 2'b00;
      p = (e == 5) ? 2'b01 : 2'b00;
      r = (e == 25) ? 2'b01 : 2'b00;
      chk("clean_press", e, ev(l, p, r));
      if (e == 19) btn_raw = 2'b00;
    end

    // 3: bounce on btnU: 1,0,1,0,1 then held
    for (int e = 0; e < 13; e++) begin
      btn_raw = (e == 1 || e == 3) ? 2'b00 : 2'b10;
      step();
      l = (e >= 9) ? 2'b10 : 2'b00;
      p = (e == 9) ? 2'b10 : 2'b00;
      chk("bounce", e, ev(l, p, 2'b00));
    end
    btn_raw = 2'b00;
    for (int e = 0; e < 7; e++) begin
      step();
      l = (e < 5) ? 2'b10 : 2'b00;
      r = (e == 5) ? 2'b10 : 2'b00;
      chk("bounce_release", e, ev(l, 2'b00, r));
    end

    // 4: three-sample glitch on btnD is rejected
    for (int e = 0; e < 11; e++) begin
      btn_raw = (e < 3) ? 2'b01 : 2'b00;
      step();
      chk("glitch", e, 7'd0);
    end

    // 5: reset during PRESS_PEND, button held; fresh window after reset
    btn_raw = 2'b01;
    for (int e = 0; e < 13; e++) begin
      reset = (e >= 3 && e <= 5) ? 1'b0 : 1'b1;
      step();
      l = (e >= 11) ? 2'b01 : 2'b00;
      p = (e == 11) ? 2'b01 : 2'b00;
      chk("reset_mid_pend", e, ev(l, p, 2'b00));
    end
    reset   = 1'b1;
    btn_raw = 2'b00;
    for (int e = 0; e < 7; e++) begin
      step();
      l = (e < 5) ? 2'b01 : 2'b00;
      r = (e == 5) ? 2'b01 : 2'b00;
      chk("reset_mid_release", e, ev(l, 2'b00, r));
    end

    // 6: long hold on btnD, release sampled at edge 22
    btn_raw = 2'b01;
    for (int e = 0; e < 31; e++) begin
      step();
      l = (e >= 5 && e < 27) ? 2'b01 : 2'b00;
`ifdef PONG_BTN_REPEAT_EN
      p = (e == 5 || e == 15 || e == 18 || e == 21) ? 2'b01 : 2'b00;
`else
      p = (e == 5) ? 2'b01 : 2'b00;
`endif
      r = (e == 27) ? 2'b01 : 2'b00;
      chk("long_hold", e, ev(l, p, r));
      if (e == 21) btn_raw = 2'b00;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
